icache_direct: RTL and testbench

- Direct-mapped, one-word-block instruction cache between the fetch stage and memory control.
- Serves hits combinationally from a register-based frame array.
- On a miss, runs a fill FSM that drives memory control's instruction request (iREN/iaddr) and consumes iload/iwait.
- Memory control deprioritises instruction traffic while the data side is active; the cache tolerates arbitrarily long iwait.

---
 rtl/icache_direct_if.sv | 36 +++
 rtl/icache_direct.sv | 116 +++++++++++
 tb/tb_icache_direct.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_direct_if.sv
// ----------------------------------------------------------------------------
// icache_direct_if
//   Bundles the instruction-cache bus signals: the fetch-stage side
//   (imemREN/imemaddr -> ihit/imemload) and the memory-control side
//   (iREN/iaddr -> iwait/iload).
//
//   Handshake: the fetch stage holds imemREN/imemaddr and may advance only in
//   a cycle where ihit=1 (imemload is valid in that same cycle). Towards memory
//   control the cache holds iREN=1 with a constant iaddr until a cycle with
//   iwait=0; iload is valid exactly in that cycle. iwait is meaningless while
//   iREN=0.
//
//   Modports:
//     slave  - the cache's view (drives ihit/imemload/iREN/iaddr)
//     master - the environment's view (fetch stage + memory control)
// ----------------------------------------------------------------------------
interface icache_direct_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );
endinterface

// File: rtl/icache_direct.sv
// ----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped instruction cache with one-word blocks. Hits are served
//   combinationally from a flop-based frame array; a miss captures the
//   word-aligned address and runs a two-state fill FSM that requests the word
//   from memory control for as long as iwait stays high.
//
//   Ports:
//     CLK       - clock, rising edge
//     nRST      - asynchronous active-low reset
//     bus       - icache_direct_if.slave (fetch side + memory-control side)
//     dbg_state - current FSM state (0 = IDLE, 1 = FETCH)
// ----------------------------------------------------------------------------
module icache_direct #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic                 CLK,
    input  logic                 nRST,
    icache_direct_if.slave       bus,
    output logic                 dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        fill_q, fill_d;
    logic [SETS-1:0]    valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [31:0]        data_q [SETS];
    logic               wr_en;

    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;

    // Byte-offset bits of the request are not part of the lookup.
    logic               unused_addr_bits;
    assign unused_addr_bits = &{1'b0, bus.imemaddr[1:0]};

    assign req_idx  = bus.imemaddr[IDX_W+1:2];
    assign req_tag  = bus.imemaddr[31:IDX_W+2];
    assign fill_idx = fill_q[IDX_W+1:2];
    assign fill_tag = fill_q[31:IDX_W+2];

    assign hit = bus.imemREN & valid_q[req_idx] & (tag_q[req_idx] == req_tag);

    assign dbg_state = state_q;

    always_comb begin
        state_d      = state_q;
        fill_d       = fill_q;
        valid_d      = valid_q;
        wr_en        = 1'b0;
        bus.ihit     = 1'b0;
        bus.imemload = 32'h0;
        bus.iREN     = 1'b0;
        bus.iaddr    = 32'h0;

        case (state_q)
            IDLE: begin
                if (bus.imemREN) begin
                    if (hit) begin
                        bus.ihit     = 1'b1;
                        bus.imemload = data_q[req_idx];
                    end else begin
                        fill_d  = {bus.imemaddr[31:2], 2'b00};
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                // The request is not cancelled if the fetch stage moves on:
                // memory control may already be mid-access.
                bus.iREN  = 1'b1;
                bus.iaddr = fill_q;
                if (!bus.iwait) begin
                    wr_en             = 1'b1;
                    valid_d[fill_idx] = 1'b1;
                    state_d           = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            fill_q  <= 32'h0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data need no reset: they are only observed behind a valid bit.
    // wr_en is only ever set in FETCH, which reset forces out of.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= bus.iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// ----------------------------------------------------------------------------
// tb_icache_direct
//   Directed bench for icache_direct (SETS=16). Stimulus tasks push expected
//   hit data and expected fill addresses into queues; a negedge monitor pops
//   and compares whenever the DUT shows ihit=1 or completes a fill.
// ----------------------------------------------------------------------------
module tb_icache_direct;

    logic clk;
    logic nrst;
    logic dbg_state;

    icache_direct_if bus();

    icache_direct #(.SETS(16)) dut (
        .CLK       (clk),
        .nRST      (nrst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // -------------------------------------------------------------- scoreboard
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (bus.ihit === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_hit: got ihit=1 data %h expected no hit at %0t",
                             bus.imemload, $time);
                end else begin
                    check("hit_data", bus.imemload, exp_q.pop_front());
                end
            end
            if (bus.iREN === 1'b1 && bus.iwait === 1'b0) begin
                if (exp_addr_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_fill: got fill of %h expected none at %0t",
                             bus.iaddr, $time);
                end else begin
                    check("fill_addr", bus.iaddr, exp_addr_q.pop_front());
                end
            end
            check("hit_and_ren", {31'b0, bus.ihit & bus.iREN}, 32'h0);
        end
    end

    // ----------------------------------------------------------------- drivers
    // One cycle expecting a hit with the given data.
    task automatic do_hit(input logic [31:0] addr, input logic [31:0] exp);
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        exp_q.push_back(exp);
        @(negedge clk);
        check("hit_no_ren", {31'b0, bus.iREN}, 32'h0);
        @(posedge clk); #1;
        bus.imemREN = 1'b0;
    endtask

    // Miss, FETCH with `waits` stalled cycles, fill with `data`, then one hit.
    task automatic do_miss(input logic [31:0] addr, input int waits, input logic [31:0] data);
        logic [31:0] fa;
        fa = {addr[31:2], 2'b00};
        bus.imemREN  = 1'b1;
        bus.imemaddr = addr;
        @(negedge clk);
        check("miss_ihit", {31'b0, bus.ihit}, 32'h0);
        check("miss_idle_ren", {31'b0, bus.iREN}, 32'h0);
        @(posedge clk); #1;
        bus.iwait = 1'b1;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            check("stall_ren", {31'b0, bus.iREN}, 32'h1);
            check("stall_iaddr", bus.iaddr, fa);
            check("stall_ihit", {31'b0, bus.ihit}, 32'h0);
            check("stall_state", {31'b0, dbg_state}, 32'h1);
            @(posedge clk); #1;
        end
        exp_addr_q.push_back(fa);
        bus.iwait = 1'b0;
        bus.iload = data;
        @(posedge clk); #1;
        // iload garbage while idle must never be captured
        bus.iload = 32'hDEAD_BEEF;
        exp_q.push_back(data);
        @(posedge clk); #1;
        bus.imemREN = 1'b0;
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        nrst         = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b0;
        bus.iload    = 32'h0;
        #12;
        check("rst_ihit", {31'b0, bus.ihit}, 32'h0);
        check("rst_iren", {31'b0, bus.iREN}, 32'h0);
        check("rst_iaddr", bus.iaddr, 32'h0);
        check("rst_imemload", bus.imemload, 32'h0);
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // First fill, RAM latency 2 (one stalled cycle + completing cycle)
        do_miss(32'h0000_0000, 1, 32'h2001_0004);

        // Re-read same word, byte offset ignored
        do_hit(32'h0000_0000, 32'h2001_0004);
        do_hit(32'h0000_0002, 32'h2001_0004);

        // imemREN low: no hit, zero data even though the frame is valid
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0000_0000;
        @(negedge clk);
        check("noreq_ihit", {31'b0, bus.ihit}, 32'h0);
        check("noreq_data", bus.imemload, 32'h0);
        @(posedge clk); #1;

        // Conflict pair on index 1
        do_miss(32'h0000_0004, 0, 32'h1111_0004);
        do_miss(32'h0000_0044, 0, 32'h2222_0044);
        do_miss(32'h0000_0004, 0, 32'h3333_0004);
        do_hit(32'h0000_0004, 32'h3333_0004);

        // Long stall while the data side is busy
        do_miss(32'h0000_0100, 10, 32'h0100_0100);

        // Address changes one cycle into FETCH
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0200;
        @(negedge clk);
        check("chg_miss", {31'b0, bus.ihit}, 32'h0);
        @(posedge clk); #1;
        bus.imemaddr = 32'h0000_0300;
        bus.iwait    = 1'b1;
        @(negedge clk);
        check("chg_iaddr_held", bus.iaddr, 32'h0000_0200);
        @(posedge clk); #1;
        exp_addr_q.push_back(32'h0000_0200);
        bus.iwait = 1'b0;
        bus.iload = 32'hAAAA_0200;
        @(posedge clk); #1;
        bus.iload = 32'hDEAD_BEEF;
        @(negedge clk);
        check("chg_new_miss", {31'b0, bus.ihit}, 32'h0);
        check("chg_idle_state", {31'b0, dbg_state}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        check("chg_refetch_iaddr", bus.iaddr, 32'h0000_0300);
        exp_addr_q.push_back(32'h0000_0300);
        bus.iload = 32'hBBBB_0300;
        @(posedge clk); #1;
        bus.iload = 32'hDEAD_BEEF;
        exp_q.push_back(32'hBBBB_0300);
        @(posedge clk); #1;
        bus.imemREN = 1'b0;
        do_miss(32'h0000_0200, 0, 32'hCCCC_0200);

        // Reset in the middle of a FETCH
        bus.imemREN  = 1'b1;
        bus.imemaddr = 32'h0000_0400;
        @(posedge clk); #1;
        bus.iwait = 1'b1;
        @(negedge clk);
        check("pre_rst_ren", {31'b0, bus.iREN}, 32'h1);
        #2;
        nrst = 1'b0;
        #1;
        check("async_rst_ren", {31'b0, bus.iREN}, 32'h0);
        check("async_rst_state", {31'b0, dbg_state}, 32'h0);
        bus.imemREN = 1'b0;
        bus.iwait   = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Everything previously filled must miss now
        do_miss(32'h0000_0004, 0, 32'h4444_0004);
        do_miss(32'h0000_0100, 2, 32'h5555_0100);
        do_miss(32'h0000_0200, 0, 32'h6666_0200);

        repeat (2) @(posedge clk);
        #1;
        check("leftover_hits", exp_q.size(), 32'h0);
        check("leftover_fills", exp_addr_q.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
